// File: rtl/seg_pkg.sv
// Shared types and constants for the eight-digit seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // True when digit idx (never digit 0) and every more-significant nibble are zero.
  function automatic logic lz_blank(input logic [31:0] val, input logic [2:0] idx);
    logic any_nz;
    any_nz = 1'b0;
    for (int i = 1; i < 8; i++)
      if (i >= int'(idx)) any_nz = any_nz | (val[4*i +: 4] != 4'h0);
    return (idx != 3'd0) && !any_nz;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment glyph, bit order {G,F,E,D,C,B,A}.
module hex_to_seg7 (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed 8-digit display scanner with blanking gaps, leading-zero
// suppression and frame-synchronous (tear-free) display updates.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done,
  output logic [31:0] shown_value
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DRV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_disp;
  logic [7:0]    r_dp_reg;
  logic [31:0]   r_shadow;
  logic [7:0]    r_shadow_dp;
  logic          r_pending;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [7:0]    r_an;

  logic [3:0] w_nib;
  logic [6:0] w_glyph;
  logic       w_drv_end;
  logic       w_boundary;
  logic       w_lz;

  assign w_nib      = r_disp[4*r_idx +: 4];
  assign w_drv_end  = (r_state == S_DRIVE) && (r_cnt == DRV_LAST);
  assign w_boundary = w_drv_end && (r_idx == 3'd7);
  assign w_lz       = LZ_SUPPRESS && lz_blank(r_disp, r_idx);

  hex_to_seg7 u_dec (
    .i_hex (w_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_disp      <= '0;
      r_dp_reg    <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_pending   <= 1'b0;
      r_seg       <= SEG_OFF;
      r_an        <= AN_OFF;
      r_dp        <= 1'b1;
    end else begin
      case (r_state)
        S_BLANK: begin
          if (r_cnt == BLK_LAST) begin
            r_state <= S_DRIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (w_drv_end) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_BLANK;
      endcase

      // Outputs lag the FSM by one cycle so they come straight from flops.
      if (r_state == S_DRIVE) begin
        r_seg <= w_glyph;
        r_dp  <= ~r_dp_reg[r_idx];
        r_an  <= w_lz ? AN_OFF : ~(8'd1 << r_idx);
      end else begin
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
        r_an  <= AN_OFF;
      end

      // A load landing on the boundary bypasses the shadow entirely.
      if (w_boundary) begin
        if (load) begin
          r_disp   <= load_data;
          r_dp_reg <= load_dp;
        end else if (r_pending) begin
          r_disp   <= r_shadow;
          r_dp_reg <= r_shadow_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_shadow    <= load_data;
        r_shadow_dp <= load_dp;
        r_pending   <= 1'b1;
      end
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_done  = w_boundary & ~reset;
  assign shown_value = r_disp;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with REFRESH_DIV=4, BLANK_CYCLES=2.
module tb_seg_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;
  logic [31:0] shown_value;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (2),
    .LZ_SUPPRESS  (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done),
    .shown_value (shown_value)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpm;
    logic [7:0]  drv_mask;  // digits expected to have their anode driven
  } vec_t;

  vec_t       vecs [7];
  logic [6:0] gly  [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_frame_done: no pulse within 200 cycles");
    end
  endtask

  // Called in the boundary cycle; checks the whole following frame.
  task automatic scan_check(input vec_t v, input int vn);
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d, r;
    tick();
    chk($sformatf("v%0d shown", vn), shown_value, v.data);
    for (int p = 0; p < 48; p++) begin
      tick();
      d = p / 6;
      r = p % 6;
      if (r < 2) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = v.drv_mask[d] ? ~(8'd1 << d) : 8'hFF;
        e_seg = gly[v.data[4*d +: 4]];
        e_dp  = ~v.dpm[d];
      end
      chk($sformatf("v%0d p%0d an", vn, p), an, e_an);
      chk($sformatf("v%0d p%0d seg", vn, p), seg, e_seg);
      chk($sformatf("v%0d p%0d dp", vn, p), dp, e_dp);
      chk($sformatf("v%0d p%0d frame_done", vn, p), frame_done, (p == 46));
    end
  endtask

  initial begin
    bit          ok;
    bit          torn;
    logic [31:0] old;

    gly = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{data: 32'h89ABCDEF, dpm: 8'h00, drv_mask: 8'hFF};
    vecs[1] = '{data: 32'h00000012, dpm: 8'h00, drv_mask: 8'h03};
    vecs[2] = '{data: 32'h00000000, dpm: 8'h01, drv_mask: 8'h01};
    vecs[3] = '{data: 32'h10000000, dpm: 8'h00, drv_mask: 8'hFF};
    vecs[4] = '{data: 32'h00500300, dpm: 8'h00, drv_mask: 8'h3F};
    vecs[5] = '{data: 32'h89ABCDEF, dpm: 8'h04, drv_mask: 8'hFF};
    vecs[6] = '{data: 32'h0000F000, dpm: 8'h08, drv_mask: 8'h0F};

    reset = 1'b1; load = 1'b0; load_data = '0; load_dp = '0;
    repeat (3) tick();
    chk("rst an", an, 8'hFF);
    chk("rst seg", seg, 7'h7F);
    chk("rst dp", dp, 1'b1);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst shown", shown_value, 32'h0);

    reset = 1'b0;
    tick(); chk("post-rst c1 an", an, 8'hFF);
    tick(); chk("post-rst c2 an", an, 8'hFF);
    tick(); chk("post-rst c3 an", an, 8'hFE);
    chk("post-rst c3 seg", seg, 7'h40);

    for (int v = 0; v < 7; v++) begin
      load_data = vecs[v].data; load_dp = vecs[v].dpm; load = 1'b1;
      tick();
      load = 1'b0;
      wait_fd(ok);
      if (ok) scan_check(vecs[v], v);
    end

    // Two loads mid-frame: last write wins, no change until the boundary.
    old = vecs[6].data;
    repeat (21) tick();
    load_data = 32'h11111111; load_dp = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    load_data = 32'h22222222; load = 1'b1;
    tick();
    load = 1'b0;
    torn = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (shown_value !== old) torn = 1'b1;
      if (frame_done) begin ok = 1'b1; break; end
      tick();
    end
    chk("no tearing before boundary", torn, 1'b0);
    chk("boundary reached", ok, 1'b1);
    tick();
    chk("last write wins", shown_value, 32'h22222222);

    // Load exactly on the boundary cycle goes straight to the display.
    wait_fd(ok);
    load_data = 32'h00005555; load_dp = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    chk("boundary load shown", shown_value, 32'h00005555);
    chk("boundary load pending", dut.r_pending, 1'b0);

    // Reset during the idx 5 drive slot, with a load that must be ignored.
    repeat (33) tick();
    reset = 1'b1; load = 1'b1; load_data = 32'hAAAAAAAA;
    tick();
    chk("mid-frame rst an", an, 8'hFF);
    chk("mid-frame rst shown", shown_value, 32'h0);
    chk("mid-frame rst frame_done", frame_done, 1'b0);
    tick();
    load = 1'b0; reset = 1'b0;
    tick(); chk("restart c1 an", an, 8'hFF);
    tick(); chk("restart c2 an", an, 8'hFF);
    tick(); chk("restart c3 an", an, 8'hFE);
    wait_fd(ok);
    tick();
    chk("load during reset ignored", shown_value, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, drive cycles per digit (legal range >= 2).
REQ-002 Parameter BLANK_CYCLES, default 1000, all-off cycles before each digit drive (legal range >= 1).
REQ-003 Parameter LZ_SUPPRESS, default 1, enables leading-zero blanking.
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 Port load, input, 1, one-cycle write strobe from processor store path.
REQ-007 Port load_data, input, 32, eight hex nibbles; nibble i feeds digit i.
REQ-008 Port load_dp, input, 8, decimal-point mask; bit i lights DP on digit i.
REQ-009 Port seg, output, 7, active-low segments; seg[0]=CA ... seg[6]=CG.
REQ-010 Port dp, output, 1, active-low decimal point.
REQ-011 Port an, output, 8, active-low anode enables; an[i] selects digit i.
REQ-012 Port frame_done, output, 1, one-cycle pulse at end of each full 8-digit scan.
REQ-013 Port shown_value, output, 32, value currently being scanned (display register).

Function
REQ-014 The FSM SHALL have states S_BLANK and S_DRIVE, with a cycle counter and 3-bit digit index idx.
REQ-015 S_BLANK SHALL last exactly BLANK_CYCLES cycles, then go to S_DRIVE with counter cleared.
REQ-016 S_DRIVE SHALL last exactly REFRESH_DIV cycles, then go to S_BLANK with idx incremented; idx wraps 7 -> 0.
REQ-017 seg, dp and an SHALL be registered: values in cycle n reflect FSM state and idx in cycle n-1.
REQ-018 In S_BLANK, outputs SHALL be an=8'hFF, seg=7'h7F, dp=1.
REQ-019 In S_DRIVE, an SHALL be all ones except an[idx]=0; seg SHALL be the hex glyph of nibble idx (0-9, A-F; b and d lowercase); dp SHALL be ~dp_reg[idx].
REQ-020 Leading-zero rule: if LZ_SUPPRESS=1, idx!=0, and nibbles idx..7 of the display register are all zero, an SHALL stay 8'hFF for that drive slot, with timing unchanged.
REQ-021 A load pulse SHALL capture load_data/load_dp into a shadow register and set pending; a later load before the frame boundary overwrites the shadow (last write wins).
REQ-022 The frame boundary is the last S_DRIVE cycle of idx=7: frame_done SHALL pulse for exactly that cycle.
REQ-023 At the frame boundary, if pending, shadow SHALL be copied to the display register and dp_reg, and pending cleared. The display register never changes mid-frame (no tearing).
REQ-024 If load coincides with the frame-boundary cycle, load_data/load_dp SHALL be written directly to the display register and dp_reg, and pending SHALL end cleared.
REQ-025 shown_value SHALL equal the display register.

Reset
REQ-026 While reset is high: state=S_BLANK, counter=0, idx=0, display register=0, shadow=0, dp_reg=0, pending=0.
REQ-027 While reset is high, the registered outputs SHALL be an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
REQ-028 Reset asserted mid-frame SHALL abort the scan; loads during reset SHALL be ignored.
REQ-029 The first S_DRIVE (idx 0) SHALL begin BLANK_CYCLES cycles after reset deasserts.

Structure
REQ-030 Package seg_pkg SHALL hold the state enum and constants SEG_OFF=7'h7F and AN_OFF=8'hFF.
REQ-031 Hex-to-glyph decode SHALL be a combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out).
REQ-032 The block SHALL contain no clock dividers or generated clocks; pacing is by counter only.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2; frame = 48 cycles)
REQ-033 Scenario 1: reset, then load 32'h89ABCDEF with load_dp=0. After the next boundary, the following frame SHALL show digit 0 seg=0001110 (F) with an=8'hFE for 4 cycles, preceded by 2 blank cycles.
REQ-034 Scenario 2: load 32'h00000012 with LZ_SUPPRESS=1. Digits 0/1 SHALL be driven; idx 2-7 SHALL keep an=8'hFF. frame_done period SHALL be 48 cycles.
REQ-035 Scenario 3: load 32'h11111111 at mid-frame, then 32'h22222222 before the boundary. shown_value SHALL stay at the old value until the boundary, then become 32'h22222222.
REQ-036 Scenario 4: load 32'h00005555 on the exact frame_done cycle. shown_value SHALL be 32'h00005555 on the next cycle and pending SHALL be 0.
REQ-037 Scenario 5: assert reset during S_DRIVE of idx 5. The next cycle SHALL show an=8'hFF and shown_value=0; idx 0 drive SHALL restart 2 cycles after release.
REQ-038 Scenario 6: load_dp=8'h04. dp SHALL be 0 only while an=8'hFB, and 1 at all other times.
